// File: rtl/fp16_pool_pkg.sv
// fp16_pool_pkg: shared FP16 constants, classification/ordering helpers and
// the FSM state encoding for the max-pooling reducer.
package fp16_pool_pkg;

    localparam int          DATA_WIDTH   = 16;
    localparam logic [15:0] FP16_QNAN    = 16'h7E00;
    localparam logic [4:0]  FP16_EXP_MAX = 5'h1F;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DONE  = 2'd2
    } pool_state_e;

    // NaN: all-ones exponent with a non-zero mantissa.
    function automatic logic fp16_is_nan(input logic [15:0] x);
        return (x[14:10] == FP16_EXP_MAX) && (x[9:0] != 10'd0);
    endfunction

    // Monotonic unsigned ordering key: negatives are bit-inverted, positives
    // get the sign bit flipped, so a plain unsigned compare orders the values.
    function automatic logic [15:0] fp16_key(input logic [15:0] x);
        return x[15] ? ~x : (x ^ 16'h8000);
    endfunction

    // Either signed zero (the ordering key alone would rank -0 below +0).
    function automatic logic fp16_is_zero(input logic [15:0] x);
        return (x[14:0] == 15'd0);
    endfunction

endpackage

// File: rtl/fp16_max2.sv
// fp16_max2: combinational two-input FP16 max for one lane.
// a_i is the running accumulator (with its sticky NaN flag), b_i the new
// element. sel_o is set when the new element replaces the accumulator;
// ties (including -0 vs +0) keep the accumulator, i.e. the earlier element.
module fp16_max2
    import fp16_pool_pkg::*;
(
    input  logic [DATA_WIDTH-1:0] a_i,
    input  logic                  a_nan_i,
    input  logic [DATA_WIDTH-1:0] b_i,
    output logic [DATA_WIDTH-1:0] y_o,
    output logic                  nan_o,
    output logic                  sel_o
);

    logic b_nan_s;
    logic both_zero_s;
    logic b_gt_s;

    // Select between accumulator and new element; NaN is sticky and wins.
    always_comb begin
        b_nan_s     = fp16_is_nan(b_i);
        both_zero_s = fp16_is_zero(a_i) && fp16_is_zero(b_i);
        b_gt_s      = !both_zero_s && (fp16_key(b_i) > fp16_key(a_i));
        y_o         = a_i;
        nan_o       = a_nan_i;
        sel_o       = 1'b0;
        if (a_nan_i) begin
            y_o   = a_i;
            nan_o = 1'b1;
            sel_o = 1'b0;
        end else if (b_nan_s) begin
            y_o   = FP16_QNAN;
            nan_o = 1'b1;
            sel_o = 1'b1;
        end else if (b_gt_s) begin
            y_o   = b_i;
            nan_o = 1'b0;
            sel_o = 1'b1;
        end else begin
            y_o   = a_i;
            nan_o = 1'b0;
            sel_o = 1'b0;
        end
    end

endmodule

// File: rtl/max_pool_unit_vec.sv
// max_pool_unit_vec: multi-lane FP16 max-pooling reducer with valid/ready
// handshakes on both sides. Each window of data_num elements (0 treated as
// 1) yields the per-lane maximum; a NaN anywhere in a lane's window forces
// that lane's result to the canonical quiet NaN.
// Optional build macro MAXPOOL_ARGMAX_EN adds the result_idx port reporting
// the per-lane 0-based position of the kept element.
module max_pool_unit_vec #(
    parameter int DATA_WIDTH    = 16,
    parameter int LANES         = 4,
    parameter int CLK_NUM_WIDTH = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [CLK_NUM_WIDTH-1:0]      data_num,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [LANES*DATA_WIDTH-1:0]   in_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [LANES*DATA_WIDTH-1:0]   result
`ifdef MAXPOOL_ARGMAX_EN
    ,
    output logic [LANES*CLK_NUM_WIDTH-1:0] result_idx
`endif
);

    import fp16_pool_pkg::*;

    localparam logic [CLK_NUM_WIDTH-1:0] CNT_ZERO = {CLK_NUM_WIDTH{1'b0}};
    localparam logic [CLK_NUM_WIDTH-1:0] CNT_ONE  = {{(CLK_NUM_WIDTH-1){1'b0}}, 1'b1};

    pool_state_e                state_q, state_d;
    logic [CLK_NUM_WIDTH-1:0]   len_q, len_d;
    logic [CLK_NUM_WIDTH-1:0]   count_q, count_d;
    logic [CLK_NUM_WIDTH-1:0]   win_len_s;
    logic                       out_valid_q, out_valid_d;
    logic                       accept_s;
    logic                       start_s;
    logic                       step_s;

    logic [DATA_WIDTH-1:0]      acc_q [LANES];
    logic [DATA_WIDTH-1:0]      acc_d [LANES];
    logic [DATA_WIDTH-1:0]      lane_data_s [LANES];
    logic [DATA_WIDTH-1:0]      max_y_s [LANES];
    logic [LANES-1:0]           nan_q, nan_d;
    logic [LANES-1:0]           max_nan_s;
    logic [LANES-1:0]           max_sel_s;
`ifdef MAXPOOL_ARGMAX_EN
    logic [CLK_NUM_WIDTH-1:0]   idx_q [LANES];
    logic [CLK_NUM_WIDTH-1:0]   idx_d [LANES];
`endif

    assign in_ready  = ~out_valid_q | out_ready;
    assign accept_s  = in_valid & in_ready;
    assign win_len_s = (data_num == CNT_ZERO) ? CNT_ONE : data_num;
    assign out_valid = out_valid_q;

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        assign lane_data_s[g] = in_data[g*DATA_WIDTH +: DATA_WIDTH];

        fp16_max2 u_max2 (
            .a_i     (acc_q[g]),
            .a_nan_i (nan_q[g]),
            .b_i     (lane_data_s[g]),
            .y_o     (max_y_s[g]),
            .nan_o   (max_nan_s[g]),
            .sel_o   (max_sel_s[g])
        );
    end

    // Window sequencing: decide whether this cycle starts a window, extends
    // it, or retires the result, and compute the next state/counters.
    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        count_d = count_q;
        start_s = 1'b0;
        step_s  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    start_s = 1'b1;
                end else begin
                    start_s = 1'b0;
                end
            end
            ST_ACCUM: begin
                if (accept_s) begin
                    step_s = 1'b1;
                end else begin
                    step_s = 1'b0;
                end
            end
            ST_DONE: begin
                if (out_ready && accept_s) begin
                    start_s = 1'b1;
                end else if (out_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (start_s) begin
            len_d   = win_len_s;
            count_d = CNT_ONE;
            state_d = (win_len_s == CNT_ONE) ? ST_DONE : ST_ACCUM;
        end else if (step_s) begin
            count_d = count_q + CNT_ONE;
            if ((count_q + CNT_ONE) == len_q) begin
                state_d = ST_DONE;
            end else begin
                state_d = ST_ACCUM;
            end
        end else begin
            count_d = count_q;
        end
        out_valid_d = (state_d == ST_DONE);
    end

    // Per-lane accumulator update: load on the first element, fold in the
    // max2 result on later elements, hold otherwise.
    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            acc_d[l] = acc_q[l];
            nan_d[l] = nan_q[l];
`ifdef MAXPOOL_ARGMAX_EN
            idx_d[l] = idx_q[l];
`endif
            if (start_s) begin
                if (fp16_is_nan(lane_data_s[l])) begin
                    acc_d[l] = FP16_QNAN;
                    nan_d[l] = 1'b1;
                end else begin
                    acc_d[l] = lane_data_s[l];
                    nan_d[l] = 1'b0;
                end
`ifdef MAXPOOL_ARGMAX_EN
                idx_d[l] = CNT_ZERO;
`endif
            end else if (step_s) begin
                nan_d[l] = max_nan_s[l];
                if (max_sel_s[l]) begin
                    acc_d[l] = max_y_s[l];
`ifdef MAXPOOL_ARGMAX_EN
                    idx_d[l] = count_q;
`endif
                end else begin
                    acc_d[l] = acc_q[l];
                end
            end else begin
                acc_d[l] = acc_q[l];
            end
        end
    end

    // State, counters and per-lane accumulators; reset aborts any window.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            len_q       <= CNT_ONE;
            count_q     <= CNT_ZERO;
            out_valid_q <= 1'b0;
            nan_q       <= {LANES{1'b0}};
            for (int l = 0; l < LANES; l++) begin
                acc_q[l] <= {DATA_WIDTH{1'b0}};
`ifdef MAXPOOL_ARGMAX_EN
                idx_q[l] <= CNT_ZERO;
`endif
            end
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            count_q     <= count_d;
            out_valid_q <= out_valid_d;
            nan_q       <= nan_d;
            for (int l = 0; l < LANES; l++) begin
                acc_q[l] <= acc_d[l];
`ifdef MAXPOOL_ARGMAX_EN
                idx_q[l] <= idx_d[l];
`endif
            end
        end
    end

    // Pack the registered accumulators onto the output buses.
    always_comb begin
        result = {(LANES*DATA_WIDTH){1'b0}};
`ifdef MAXPOOL_ARGMAX_EN
        result_idx = {(LANES*CLK_NUM_WIDTH){1'b0}};
`endif
        for (int l = 0; l < LANES; l++) begin
            result[l*DATA_WIDTH +: DATA_WIDTH] = acc_q[l];
`ifdef MAXPOOL_ARGMAX_EN
            result_idx[l*CLK_NUM_WIDTH +: CLK_NUM_WIDTH] = idx_q[l];
`endif
        end
    end

endmodule

// File: tb/tb_max_pool_unit_vec.sv
// Scoreboard bench for max_pool_unit_vec (4 lanes x FP16, 8-bit window length).
// Stimulus pushes hand-computed window results into a queue; a monitor pops
// and compares on every out_valid & out_ready. Index checks are compiled in
// when MAXPOOL_ARGMAX_EN is defined.
module tb_max_pool_unit_vec;

    logic        clk;
    logic        rst;
    logic [7:0]  data_num;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] result;
`ifdef MAXPOOL_ARGMAX_EN
    logic [31:0] result_idx;
`endif

    typedef struct {
        logic [63:0] res;
        logic [31:0] idx;
    } exp_t;

    exp_t sb_q[$];
    int   check_cnt = 0;
    int   pass_cnt  = 0;

    max_pool_unit_vec dut (
        .clk       (clk),
        .rst       (rst),
        .data_num  (data_num),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result)
`ifdef MAXPOOL_ARGMAX_EN
        ,
        .result_idx(result_idx)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp_v);
        check_cnt++;
        if (act === exp_v) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, act, exp_v);
    endtask

    task automatic push_exp(input logic [63:0] r, input logic [31:0] i);
        exp_t e;
        e.res = r;
        e.idx = i;
        sb_q.push_back(e);
    endtask

    // Drive one element and wait (bounded) until it is accepted.
    task automatic send(input logic [63:0] d, input logic [7:0] n);
        int   budget;
        logic acc;
        budget   = 0;
        acc      = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
        data_num = n;
        while (!acc && budget < 50) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            budget++;
        end
        if (!acc) begin
            check_cnt++;
            $display("FAIL accept_timeout: in_ready stayed 0 for %0d cycles, required 1", budget);
        end
        in_valid = 1'b0;
    endtask

    // Monitor: every output handshake must match the oldest expected window.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst && out_valid && out_ready) begin
                if (sb_q.size() == 0) begin
                    check_cnt++;
                    $display("FAIL unexpected_out: got result %h, required no output", result);
                end else begin
                    e = sb_q.pop_front();
                    for (int l = 0; l < 4; l++) begin
                        chk($sformatf("lane%0d_result", l), {48'd0, result[l*16 +: 16]}, {48'd0, e.res[l*16 +: 16]});
`ifdef MAXPOOL_ARGMAX_EN
                        chk($sformatf("lane%0d_idx", l), {56'd0, result_idx[l*8 +: 8]}, {56'd0, e.idx[l*8 +: 8]});
`endif
                    end
                end
            end
        end
    end

    // Watchdog so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b0;
        in_valid  = 1'b0;
        in_data   = 64'd0;
        data_num  = 8'd0;
        out_ready = 1'b1;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_out_valid", {63'd0, out_valid}, 64'd0);
        chk("reset_result", result, 64'd0);
        rst = 1'b1;
        @(negedge clk);
        chk("reset_in_ready", {63'd0, in_ready}, 64'd1);
        @(posedge clk);
        #1;

        // T1: N=3, lane0 4000,3C00,4700 -> 4700 idx2
        push_exp(64'h7C00_C200_0000_4700, 32'h00_01_00_02);
        send(64'h7C00_C400_0000_4000, 8'd3);
        send(64'h7BFF_C200_0000_3C00, 8'd3);
        send(64'h0001_C500_0000_4700, 8'd3);
        chk("t1_latency_out_valid", {63'd0, out_valid}, 64'd1);

        // T2: N=4, signed zero tie, subnormals, equal values; data_num changes ignored
        push_exp(64'h3C00_0003_8000_4800, 32'h00_03_02_00);
        send(64'h3C00_0001_C000_4800, 8'd4);
        send(64'h3C00_0002_BC00_4000, 8'd9);
        send(64'h3C00_0001_8000_4400, 8'd9);
        send(64'h3C00_0003_0000_4200, 8'd2);

        // T3: NaN handling and infinities
        push_exp(64'h8000_7E00_7C00_7E00, 32'h00_00_01_01);
        send(64'h8000_FE00_FC00_3C00, 8'd3);
        send(64'h0000_3C00_7C00_7C01, 8'd3);
        send(64'h8000_7E00_3C00_4000, 8'd3);
        @(posedge clk);
        #1;

        // T4: backpressure, then back-to-back window with no bubble
        out_ready = 1'b0;
        push_exp(64'h7BFF_BC00_0000_4000, 32'h00_00_00_01);
        send(64'h7BFF_BC00_0000_3C00, 8'd2);
        send(64'hFBFF_C000_0000_4000, 8'd2);
        in_valid = 1'b1;
        in_data  = 64'h0DEF_9ABC_5678_1234;
        data_num = 8'd1;
        repeat (3) begin
            @(negedge clk);
            chk("bp_in_ready", {63'd0, in_ready}, 64'd0);
            chk("bp_out_valid", {63'd0, out_valid}, 64'd1);
            chk("bp_result_stable", result, 64'h7BFF_BC00_0000_4000);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        push_exp(64'h0DEF_9ABC_5678_1234, 32'h00_00_00_00);
        send(64'h0DEF_9ABC_5678_1234, 8'd1);
        chk("b2b_out_valid", {63'd0, out_valid}, 64'd1);
        chk("b2b_result", result, 64'h0DEF_9ABC_5678_1234);

        // T5: data_num=0 acts as a single-element window
        push_exp(64'hFC00_7C00_8000_3555, 32'h00_00_00_00);
        send(64'hFC00_7C00_8000_3555, 8'd0);
        chk("n0_out_valid", {63'd0, out_valid}, 64'd1);
        chk("n0_result", result, 64'hFC00_7C00_8000_3555);

        // T6: reset mid-window aborts it; next window is correct
        send(64'h1111_2222_3333_4444, 8'd4);
        send(64'h5555_1111_2222_3333, 8'd4);
        rst = 1'b0;
        @(negedge clk);
        chk("abort_out_valid", {63'd0, out_valid}, 64'd0);
        chk("abort_result", result, 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (5) begin
            @(negedge clk);
            chk("abort_no_output", {63'd0, out_valid}, 64'd0);
        end
        @(posedge clk);
        #1;
        push_exp(64'h4000_C000_3800_0401, 32'h00_00_00_01);
        send(64'h4000_C000_3800_0400, 8'd2);
        send(64'h3C00_C400_3800_0401, 8'd2);

        repeat (4) @(posedge clk);
        #1;
        chk("scoreboard_drained", 64'(sb_q.size()), 64'd0);

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
